// File: rtl/video_timing_meas.sv
// -----------------------------------------------------------------------------
// video_timing_meas
//
// Purpose:
//   Video timing analyser running on the pixel clock. It measures line period,
//   active pixels per line, lines per frame and active lines per frame from
//   hs/vs/de, and provides live pixel coordinates. A lock detector reports when
//   several consecutive frames measure identically. A line-clock timeout drops
//   the measurement state when hs disappears.
//
// Parameters:
//   CNT_W        width of all counters and measurement outputs
//   HS_POL       1: hs active-high, 0: hs active-low
//   VS_POL       1: vs active-high, 0: vs active-low
//   LOCK_FRAMES  consecutive identical frames required for o_locked (>=1)
//
// Ports:
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   i_hs          horizontal sync (polarity per HS_POL)
//   i_vs          vertical sync (polarity per VS_POL)
//   i_de          data enable, active-high
//   o_pix_x       de cycles since the last hs edge (wraps)
//   o_pix_y       hs edges since the last vs edge (wraps)
//   o_h_total     clocks per line, published once per frame
//   o_h_active    de clocks per line, published once per frame
//   o_v_total     lines per frame
//   o_v_active    lines containing at least one de cycle
//   o_meas_valid  measurement outputs hold a complete frame
//   o_locked      LOCK_FRAMES consecutive matching frames seen
//   o_frame_stb   1-cycle pulse: measurement outputs just updated
//   o_timeout     1-cycle pulse: line clock counter reached all-ones
// -----------------------------------------------------------------------------
module video_timing_meas #(
    parameter int CNT_W       = 16,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic             i_de,
    output logic [CNT_W-1:0] o_pix_x,
    output logic [CNT_W-1:0] o_pix_y,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_h_active,
    output logic [CNT_W-1:0] o_v_total,
    output logic [CNT_W-1:0] o_v_active,
    output logic             o_meas_valid,
    output logic             o_locked,
    output logic             o_frame_stb,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;
    localparam int               MATCH_W = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_FRAMES);

    // Window state: IDLE waits for a vs edge to open a window, OPEN has a
    // window running but nothing published yet, VALID has published at least
    // one complete frame.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    // Saturating increment: internal counters must never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t              r_state;
    state_t              w_state_next;

    logic                r_hs_d;
    logic                r_vs_d;
    logic [CNT_W-1:0]    r_line_clk;
    logic [CNT_W-1:0]    r_de_line;
    logic [CNT_W-1:0]    r_h_tot_l;
    logic [CNT_W-1:0]    r_h_act_l;
    logic [CNT_W-1:0]    r_line_cnt;
    logic [CNT_W-1:0]    r_act_cnt;
    logic [CNT_W-1:0]    r_pix_x;
    logic [CNT_W-1:0]    r_pix_y;
    logic [CNT_W-1:0]    r_h_total;
    logic [CNT_W-1:0]    r_h_active;
    logic [CNT_W-1:0]    r_v_total;
    logic [CNT_W-1:0]    r_v_active;
    logic [MATCH_W-1:0]  r_match_cnt;
    logic                r_locked;
    logic                r_frame_stb;
    logic                r_timeout;

    logic                w_hs_n;
    logic                w_vs_n;
    logic                w_hs_edge;
    logic                w_vs_edge;
    logic                w_de_line_nz;
    logic                w_timeout_hit;
    logic                w_publish;
    logic                w_all_match;
    logic [MATCH_W-1:0]  w_match_next;

    // Sync normalisation and rising-edge detection on the active level.
    // The delayed samples reset to 1, so a sync held active through reset
    // release does not produce an edge.
    assign w_hs_n       = HS_POL ? i_hs : ~i_hs;
    assign w_vs_n       = VS_POL ? i_vs : ~i_vs;
    assign w_hs_edge    = w_hs_n & ~r_hs_d;
    assign w_vs_edge    = w_vs_n & ~r_vs_d;
    assign w_de_line_nz = (r_de_line != '0);

    // The line clock reaches all-ones on the next edge exactly when it sits one
    // below and no hs edge resets it; registering this gives a single pulse in
    // the cycle the counter shows all-ones, never repeated while saturated.
    assign w_timeout_hit = ~w_hs_edge & (r_line_clk == CNT_PRE);

    // Compare the candidate frame (pre-update latches) with the published one.
    assign w_all_match = (r_line_cnt == r_v_total)  &&
                         (r_act_cnt  == r_v_active) &&
                         (r_h_tot_l  == r_h_total)  &&
                         (r_h_act_l  == r_h_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_publish    = 1'b0;
        w_match_next = r_match_cnt;
        if (w_timeout_hit) begin
            // Losing hs invalidates everything; a fresh window is needed.
            w_state_next = ST_IDLE;
            w_match_next = '0;
        end else if (w_vs_edge) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_OPEN;
                    w_match_next = '0;
                end
                ST_OPEN: begin
                    w_state_next = ST_VALID;
                    w_publish    = 1'b1;
                    w_match_next = '0;
                end
                ST_VALID: begin
                    w_state_next = ST_VALID;
                    w_publish    = 1'b1;
                    if (w_all_match) begin
                        w_match_next = (r_match_cnt == MATCH_MAX) ? MATCH_MAX
                                                                  : r_match_cnt + 1'b1;
                    end else begin
                        w_match_next = '0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_match_next = '0;
                end
            endcase
        end
    end

    // Sync history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
        end else begin
            r_hs_d <= w_hs_n;
            r_vs_d <= w_vs_n;
        end
    end

    // Per-line measurement. The edge cycle's de belongs to the new line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_clk <= '0;
            r_de_line  <= '0;
            r_h_tot_l  <= '0;
            r_h_act_l  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (w_hs_edge) begin
                r_line_clk <= '0;
                r_de_line  <= CNT_W'(i_de);
                r_h_tot_l  <= sat_inc(r_line_clk);
                r_h_act_l  <= r_de_line;
            end else begin
                r_line_clk <= sat_inc(r_line_clk);
                if (i_de) begin
                    r_de_line <= sat_inc(r_de_line);
                end
            end
        end
    end

    // Live pixel coordinates; these are allowed to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
        end else begin
            if (w_hs_edge) begin
                r_pix_x <= '0;
            end else if (i_de) begin
                r_pix_x <= r_pix_x + 1'b1;
            end
            if (w_vs_edge) begin
                r_pix_y <= '0;
            end else if (w_hs_edge) begin
                r_pix_y <= r_pix_y + 1'b1;
            end
        end
    end

    // Frame window counters. An hs edge coincident with the vs edge starts
    // the new window, so it seeds the counters instead of closing the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_cnt <= '0;
            r_act_cnt  <= '0;
        end else if (w_vs_edge) begin
            r_line_cnt <= CNT_W'(w_hs_edge);
            r_act_cnt  <= CNT_W'(w_hs_edge & w_de_line_nz);
        end else if (w_hs_edge) begin
            r_line_cnt <= sat_inc(r_line_cnt);
            if (w_de_line_nz) begin
                r_act_cnt <= sat_inc(r_act_cnt);
            end
        end
    end

    // Published measurements and lock status. Values hold through a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_total   <= '0;
            r_h_active  <= '0;
            r_v_total   <= '0;
            r_v_active  <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_frame_stb <= 1'b0;
        end else begin
            r_frame_stb <= w_publish;
            r_match_cnt <= w_match_next;
            r_locked    <= (w_match_next == MATCH_MAX);
            if (w_publish) begin
                r_h_total  <= r_h_tot_l;
                r_h_active <= r_h_act_l;
                r_v_total  <= r_line_cnt;
                r_v_active <= r_act_cnt;
            end
        end
    end

    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_h_total    = r_h_total;
    assign o_h_active   = r_h_active;
    assign o_v_total    = r_v_total;
    assign o_v_active   = r_v_active;
    assign o_meas_valid = (r_state == ST_VALID);
    assign o_locked     = r_locked;
    assign o_frame_stb  = r_frame_stb;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_video_timing_meas.sv
`timescale 1ns/1ps
module tb_video_timing_meas;

    localparam int W  = 8;
    localparam int LF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    // Stimulus in normalised (active-high) form; DUT 1 sees inverted syncs.
    logic hs = 1'b0, vs = 1'b0, de = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] px [2], py [2], ht [2], ha [2], vt [2], va [2];
    logic         mv [2], lk [2], fs [2], to [2];

    video_timing_meas #(.CNT_W(W), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(LF)) dut_pos (
        .clk(clk), .rst_n(rst_n), .i_hs(hs), .i_vs(vs), .i_de(de),
        .o_pix_x(px[0]), .o_pix_y(py[0]), .o_h_total(ht[0]), .o_h_active(ha[0]),
        .o_v_total(vt[0]), .o_v_active(va[0]), .o_meas_valid(mv[0]), .o_locked(lk[0]),
        .o_frame_stb(fs[0]), .o_timeout(to[0]));

    video_timing_meas #(.CNT_W(W), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(LF)) dut_neg (
        .clk(clk), .rst_n(rst_n), .i_hs(~hs), .i_vs(~vs), .i_de(de),
        .o_pix_x(px[1]), .o_pix_y(py[1]), .o_h_total(ht[1]), .o_h_active(ha[1]),
        .o_v_total(vt[1]), .o_v_active(va[1]), .o_meas_valid(mv[1]), .o_locked(lk[1]),
        .o_frame_stb(fs[1]), .o_timeout(to[1]));

    typedef struct { int ht; int ha; int vt; int va; bit lk; } frame_t;
    typedef struct { int unsigned c; int x; int y; } pix_t;

    frame_t      fq[$];
    int unsigned tq[$];
    pix_t        pq[$];
    int          fidx[2] = '{0, 0};
    int          tidx[2] = '{0, 0};
    int          checks = 0, failures = 0;

    // Reference timeline: sample index of every hs edge and running de total
    // just before that edge's own cycle.
    int unsigned e_time[$];
    int unsigned e_de[$];
    int unsigned de_total, pixx_base, last_vs;
    bit          hs_prev, vs_prev, vs_seen, win_open, mvalid;
    int          streak;
    frame_t      last_f;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        e_time.delete(); e_de.delete();
        de_total = 0; pixx_base = 0; last_vs = 0;
        hs_prev = 1'b1; vs_prev = 1'b1;
        vs_seen = 1'b0; win_open = 1'b0; mvalid = 1'b0; streak = 0;
    endtask

    // Frame closing at sample T covers hs edges in [previous vs, T).
    task automatic model_vs(input int unsigned t);
        frame_t f;
        int n, na, k;
        if (win_open) begin
            n = 0; na = 0; k = -1;
            foreach (e_time[i]) begin
                if (e_time[i] < t) k = i;
                if (e_time[i] >= last_vs && e_time[i] < t) begin
                    n++;
                    if (e_de[i] != ((i > 0) ? e_de[i-1] : 0)) na++;
                end
            end
            f.ht = (k > 0) ? sat(int'(e_time[k] - e_time[k-1])) : 0;
            f.ha = (k > 0) ? sat(int'(e_de[k] - e_de[k-1])) : 0;
            f.vt = sat(n);
            f.va = sat(na);
            if (mvalid && f.ht == last_f.ht && f.ha == last_f.ha &&
                f.vt == last_f.vt && f.va == last_f.va)
                streak = (streak + 1 > LF) ? LF : streak + 1;
            else
                streak = 0;
            f.lk = (streak == LF);
            mvalid = 1'b1;
            last_f = f;
            fq.push_back(f);
        end
        win_open = 1'b1;
        vs_seen  = 1'b1;
        last_vs  = t;
    endtask

    task automatic step(input bit h, input bit v, input bit d);
        bit h_rise, v_rise;
        h_rise = h && !hs_prev;
        v_rise = v && !vs_prev;
        hs = h; vs = v; de = d;
        @(posedge clk); #1;
        if (h_rise) begin
            e_time.push_back(cyc);
            e_de.push_back(de_total);
        end
        if (v_rise) model_vs(cyc);
        if (d) de_total++;
        if (h_rise) pixx_base = de_total;
        hs_prev = h; vs_prev = v;
    endtask

    task automatic push_pix();
        pix_t p;
        int y;
        if (e_time.size() == 0) return;
        y = 0;
        foreach (e_time[i]) if (!vs_seen || e_time[i] > last_vs) y++;
        p.c = cyc;
        p.x = int'(de_total - pixx_base) % 256;
        p.y = y % 256;
        pq.push_back(p);
    endtask

    // One frame: V lines of L clocks, hs for hw clocks at line start, de on
    // lines [a0,a1) from column d0 for n clocks, vs rising at column o of line 0.
    task automatic run_frame(input int l, input int hw, input int d0, input int n,
                             input int v, input int a0, input int a1,
                             input int o, input int vw);
        int vcnt;
        vcnt = 0;
        for (int j = 0; j < v; j++) begin
            for (int p = 0; p < l; p++) begin
                if (j == 0 && p == o) vcnt = vw;
                step(p < hw, vcnt > 0, (j >= a0 && j < a1 && p >= d0 && p < d0 + n));
                if (vcnt > 0) vcnt--;
                if (p == l - 1) push_pix();
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({px[d], py[d], ht[d], ha[d], vt[d], va[d], mv[d], lk[d], fs[d], to[d]} != '0) begin
                failures++;
                $display("FAIL %s dut%0d: pix=%0d,%0d meas=%0d/%0d/%0d/%0d valid=%0b lock=%0b stb=%0b to=%0b, required all 0",
                         tag, d, px[d], py[d], ht[d], ha[d], vt[d], va[d], mv[d], lk[d], fs[d], to[d]);
            end
        end
    endtask

    // Monitor: consumes expectations whenever a DUT presents an event.
    frame_t m_f;
    pix_t   m_p;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fs[d]) begin
                checks++;
                if (fidx[d] >= fq.size()) begin
                    failures++;
                    $display("FAIL frame_stb dut%0d @%0d: unexpected pulse, got %0d/%0d/%0d/%0d", d, cyc,
                             ht[d], ha[d], vt[d], va[d]);
                end else begin
                    m_f = fq[fidx[d]];
                    fidx[d]++;
                    if (int'(ht[d]) != m_f.ht || int'(ha[d]) != m_f.ha || int'(vt[d]) != m_f.vt ||
                        int'(va[d]) != m_f.va || mv[d] !== 1'b1 || lk[d] !== m_f.lk) begin
                        failures++;
                        $display("FAIL frame dut%0d @%0d: got h=%0d/%0d v=%0d/%0d valid=%0b lock=%0b, required h=%0d/%0d v=%0d/%0d valid=1 lock=%0b",
                                 d, cyc, ht[d], ha[d], vt[d], va[d], mv[d], lk[d],
                                 m_f.ht, m_f.ha, m_f.vt, m_f.va, m_f.lk);
                    end else begin
                        $display("frame dut%0d @%0d h=%0d/%0d v=%0d/%0d lock=%0b", d, cyc,
                                 ht[d], ha[d], vt[d], va[d], lk[d]);
                    end
                end
            end
            if (to[d]) begin
                checks++;
                if (tidx[d] >= tq.size()) begin
                    failures++;
                    $display("FAIL timeout dut%0d @%0d: unexpected pulse", d, cyc);
                end else begin
                    if (cyc != tq[tidx[d]] || mv[d] !== 1'b0 || lk[d] !== 1'b0) begin
                        failures++;
                        $display("FAIL timeout dut%0d: got cycle %0d valid=%0b lock=%0b, required cycle %0d valid=0 lock=0",
                                 d, cyc, mv[d], lk[d], tq[tidx[d]]);
                    end else begin
                        $display("timeout dut%0d @%0d", d, cyc);
                    end
                    tidx[d]++;
                end
            end
        end
        if (pq.size() > 0 && pq[0].c == cyc) begin
            m_p = pq.pop_front();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (int'(px[d]) != m_p.x || int'(py[d]) != m_p.y) begin
                    failures++;
                    $display("FAIL pixel dut%0d @%0d: got x=%0d y=%0d, required x=%0d y=%0d",
                             d, cyc, px[d], py[d], m_p.x, m_p.y);
                end
            end
        end
    end

    initial begin
        int l, hw, d0, n, v, a0, a1, o, vw, rep;
        model_reset();
        // Syncs held active across reset release must not create edges.
        rst_n = 1'b0; hs = 1'b1; vs = 1'b1; de = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        model_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Steady timing with coincident hs/vs edges: lock after the 4th vs.
        repeat (5) run_frame(40, 4, 8, 24, 12, 3, 9, 0, 5);
        // Wider active region: mismatch drops lock, then relock.
        repeat (4) run_frame(40, 4, 8, 30, 12, 3, 9, 0, 5);

        // Randomised timings, each repeated a few times.
        for (int r = 0; r < 6; r++) begin
            l   = $urandom_range(60, 20);
            hw  = $urandom_range(6, 1);
            d0  = $urandom_range(l - 2, 1);
            n   = $urandom_range(l - 1 - d0, 0);
            v   = $urandom_range(14, 5);
            a0  = $urandom_range(v - 1, 0);
            a1  = $urandom_range(v, a0);
            o   = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(l - 1, 1);
            vw  = $urandom_range(8, 1);
            rep = $urandom_range(3, 1);
            repeat (rep) run_frame(l, hw, d0, n, v, a0, a1, o, vw);
        end

        // hs stops: line clock saturates 255 samples after the last edge.
        tq.push_back(e_time[e_time.size() - 1] + 255);
        win_open = 1'b0; mvalid = 1'b0; streak = 0;
        repeat (300) step(1'b0, 1'b0, 1'b0);
        repeat (4) run_frame(36, 3, 6, 20, 10, 2, 8, 5, 4);

        // Reset asserted mid-line.
        for (int p = 0; p < 15; p++) step(p < 4, 1'b0, (p >= 8 && p < 20));
        #1 rst_n = 1'b0;
        #1 check_zero("midline_reset");
        hs = 1'b0; vs = 1'b0; de = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (4) run_frame(40, 4, 8, 24, 12, 3, 9, 0, 5);
        repeat (5) step(1'b0, 1'b0, 1'b0);

        for (int d = 0; d < 2; d++) begin
            checks++;
            if (fidx[d] != fq.size()) begin
                failures++;
                $display("FAIL frame_count dut%0d: got %0d pulses, required %0d", d, fidx[d], fq.size());
            end
            checks++;
            if (tidx[d] != tq.size()) begin
                failures++;
                $display("FAIL timeout_count dut%0d: got %0d pulses, required %0d", d, tidx[d], tq.size());
            end
        end
        checks++;
        if (pq.size() != 0) begin
            failures++;
            $display("FAIL pixel_pending: %0d checkpoints not reached, required 0", pq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
